// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Iterative radix-2 UDIV/SDIV divider and sequencing FSM that
//               sits beside the EX-stage ALU.
// Revision    : 1.0
// ============================================================================
module div_sequencer #(
  parameter int                          WIDTH            = 32,
  parameter int                          ALUCONTROL_WIDTH = 6,
  parameter logic [ALUCONTROL_WIDTH-1:0] UDIV_CODE        = 6'b101110,
  parameter logic [ALUCONTROL_WIDTH-1:0] SDIV_CODE        = 6'b101111
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        DivStartE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic [WIDTH-1:0]            SrcAE,
  input  logic [WIDTH-1:0]            SrcBE,
  input  logic                        AbortE,
  output logic                        StallDivE,
  output logic                        DivBusy,
  output logic                        DivDone,
  output logic [WIDTH-1:0]            QuotientOut,
  output logic [WIDTH-1:0]            RemainderOut,
  output logic                        DivByZero
);

  localparam int             c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signQ;
  logic             r_signR;
  logic [WIDTH-1:0] r_quotOut;
  logic [WIDTH-1:0] r_remOut;
  logic             r_divByZero;
  logic             r_divBusy;
  logic             r_divDone;

  logic             w_isDiv;
  logic             w_isSigned;
  logic             w_go;
  logic             w_srcBZero;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_diff;
  logic             w_noBorrow;
  logic [WIDTH-1:0] w_remKeep;
  logic [WIDTH-1:0] w_dvdNext;
  logic [WIDTH-1:0] w_quotFix;
  logic [WIDTH-1:0] w_remFix;

  assign w_isDiv    = (ALUControlE == UDIV_CODE) || (ALUControlE == SDIV_CODE);
  assign w_isSigned = (ALUControlE == SDIV_CODE);
  assign w_go       = DivStartE & w_isDiv & ~AbortE;
  assign w_srcBZero = (SrcBE == '0);

  // Magnitudes for SDIV; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign w_absA = (w_isSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_absB = (w_isSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  // Shifted partial remainder needs one extra bit, since the divisor can use all WIDTH bits.
  assign w_diff     = {r_rem, r_dvd[WIDTH-1]} - {1'b0, r_dvs};
  assign w_noBorrow = ~w_diff[WIDTH];
  assign w_remKeep  = (r_rem << 1) | WIDTH'(r_dvd[WIDTH-1]);
  assign w_dvdNext  = (r_dvd << 1) | WIDTH'(w_noBorrow);

  assign w_quotFix = r_signQ ? -r_dvd : r_dvd;
  assign w_remFix  = r_signR ? -r_rem : r_rem;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_nextState = w_srcBZero ? DONE : RUN;
        end
      end
      RUN: begin
        if (AbortE) begin
          w_nextState = IDLE;
        end else if (r_count == c_LAST) begin
          w_nextState = FIX;
        end
      end
      FIX:     w_nextState = AbortE ? IDLE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_signQ     <= 1'b0;
      r_signR     <= 1'b0;
      r_quotOut   <= '0;
      r_remOut    <= '0;
      r_divByZero <= 1'b0;
      r_divBusy   <= 1'b0;
      r_divDone   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_divBusy <= (w_nextState == RUN) || (w_nextState == FIX);
      r_divDone <= (w_nextState == DONE);

      case (r_state)
        IDLE: begin
          if (w_go) begin
            if (w_srcBZero) begin
              r_quotOut   <= '0;
              r_remOut    <= SrcAE;
              r_divByZero <= 1'b1;
            end else begin
              r_dvd   <= w_absA;
              r_dvs   <= w_absB;
              r_rem   <= '0;
              r_count <= '0;
              r_signQ <= w_isSigned & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
              r_signR <= w_isSigned & SrcAE[WIDTH-1];
            end
          end
        end
        RUN: begin
          r_rem <= w_noBorrow ? w_diff[WIDTH-1:0] : w_remKeep;
          r_dvd <= w_dvdNext;
          if (r_count != c_LAST) begin
            r_count <= r_count + c_CW'(1);
          end
        end
        FIX: begin
          // An abort here leaves the previously completed result visible.
          if (!AbortE) begin
            r_quotOut   <= w_quotFix;
            r_remOut    <= w_remFix;
            r_divByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign StallDivE    = ((r_state == IDLE) && w_go && !w_srcBZero) ||
                        (r_state == RUN) || (r_state == FIX);
  assign DivBusy      = r_divBusy;
  assign DivDone      = r_divDone;
  assign QuotientOut  = r_quotOut;
  assign RemainderOut = r_remOut;
  assign DivByZero    = r_divByZero;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer (vector table + scoreboard).
// Revision    : 1.0
// ============================================================================
module tb_div_sequencer;

  localparam int         WIDTH = 32;
  localparam logic [5:0] UDIV  = 6'b101110;
  localparam logic [5:0] SDIV  = 6'b101111;
  localparam logic [5:0] ADDOP = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        DivStartE;
  logic [5:0]  ALUControlE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        AbortE;
  logic        StallDivE;
  logic        DivBusy;
  logic        DivDone;
  logic [31:0] QuotientOut;
  logic [31:0] RemainderOut;
  logic        DivByZero;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          doneCyc;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  div_sequencer #(
    .WIDTH(WIDTH), .ALUCONTROL_WIDTH(6), .UDIV_CODE(UDIV), .SDIV_CODE(SDIV)
  ) dut (
    .clk(clk), .reset(reset), .DivStartE(DivStartE), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AbortE(AbortE), .StallDivE(StallDivE),
    .DivBusy(DivBusy), .DivDone(DivDone), .QuotientOut(QuotientOut),
    .RemainderOut(RemainderOut), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completions are compared against the scoreboard on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset && DivDone) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("FAIL unexpectedDone: DivDone=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        check("doneCycle", 32'(cyc), 32'(e.doneCyc));
        check("quotient", QuotientOut, e.q);
        check("remainder", RemainderOut, e.r);
        check("divByZero", 32'(DivByZero), 32'(e.dbz));
        check("busyAtDone", 32'(DivBusy), 32'd0);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dbz,
                         input bit expectDone);
    exp_t e;
    DivStartE   = 1'b1;
    ALUControlE = op;
    SrcAE       = a;
    SrcBE       = b;
    AbortE      = 1'b0;
    if (expectDone) begin
      e.q = q; e.r = r; e.dbz = dbz;
      e.doneCyc = cyc + ((b == 32'd0) ? 1 : WIDTH + 2);
      sb.push_back(e);
    end
    #1 check("stallAtStart", 32'(StallDivE), 32'(b != 32'd0));
    nextCycle();
    // Scrambled inputs after the start cycle must not disturb the divide.
    DivStartE   = 1'b0;
    ALUControlE = 6'($urandom);
    SrcAE       = $urandom;
    SrcBE       = $urandom;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      nextCycle();
      n++;
    end
    if (sb.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drainTimeout: %0d results pending after %0d cycles, expected 0", sb.size(), limit);
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL globalTimeout: simulation exceeded time limit, expected to finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int n;

    vecs[0]  = '{UDIV, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{SDIV, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{SDIV, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{UDIV, 32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
    vecs[4]  = '{SDIV, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[5]  = '{UDIV, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[6]  = '{UDIV, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[7]  = '{UDIV, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[8]  = '{SDIV, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{SDIV, 32'hFFFFFFFB,   32'd0,          32'd0,          32'hFFFFFFFB,   1'b1};
    vecs[10] = '{UDIV, 32'hFFFFFFFE,   32'h80000000,   32'd1,          32'h7FFFFFFE,   1'b0};
    vecs[11] = '{SDIV, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    vecs[12] = '{UDIV, 32'd1000,       32'd9,          32'd111,        32'd1,          1'b0};

    reset = 1'b0; DivStartE = 1'b0; ALUControlE = '0; SrcAE = '0; SrcBE = '0; AbortE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstQuotient", QuotientOut, 32'd0);
    check("rstRemainder", RemainderOut, 32'd0);
    check("rstDivByZero", 32'(DivByZero), 32'd0);
    check("rstBusy", 32'(DivBusy), 32'd0);
    check("rstDone", 32'(DivDone), 32'd0);
    check("rstStall", 32'(StallDivE), 32'd0);
    reset = 1'b1;
    nextCycle();

    // UDIV 100/7 cycle by cycle: stall 0..33, busy 1..33, done only at 34.
    s = cyc;
    startOp(UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    for (int k = 1; k <= WIDTH + 2; k++) begin
      check("stallTrace", 32'(StallDivE), 32'(k <= WIDTH + 1));
      check("busyTrace", 32'(DivBusy), 32'(k <= WIDTH + 1));
      check("doneTrace", 32'(DivDone), 32'(k == WIDTH + 2));
      nextCycle();
    end
    waitDrain(5);

    // Divide by zero never stalls and completes in cycle 1.
    startOp(UDIV, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b1);
    check("dbzStallCycle1", 32'(StallDivE), 32'd0);
    check("dbzDoneCycle1", 32'(DivDone), 32'd1);
    waitDrain(5);

    for (int i = 0; i < 13; i++) begin
      startOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 1'b1);
      waitDrain(60);
    end

    // Abort in cycle 10; last completed result (1000/9) must stay visible.
    s = cyc;
    startOp(UDIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) nextCycle();
    AbortE = 1'b1; DivStartE = 1'b1; ALUControlE = UDIV;
    nextCycle();
    AbortE = 1'b0; DivStartE = 1'b0;
    check("abortCycle", 32'(cyc - s), 32'd11);
    check("abortBusy", 32'(DivBusy), 32'd0);
    check("abortStall", 32'(StallDivE), 32'd0);
    check("abortHoldQ", QuotientOut, 32'd111);
    check("abortHoldR", RemainderOut, 32'd1);
    check("abortHoldDbz", 32'(DivByZero), 32'd0);
    startOp(UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    waitDrain(60);

    // Abort beats a simultaneous start in IDLE.
    DivStartE = 1'b1; ALUControlE = UDIV; SrcAE = 32'd9; SrcBE = 32'd0; AbortE = 1'b1;
    #1 check("abortStartStall", 32'(StallDivE), 32'd0);
    nextCycle();
    DivStartE = 1'b0; AbortE = 1'b0;
    check("abortStartBusy", 32'(DivBusy), 32'd0);
    check("abortStartDbz", 32'(DivByZero), 32'd0);

    // Non-divide opcode is ignored, even with a zero divisor.
    DivStartE = 1'b1; ALUControlE = ADDOP; SrcAE = 32'd9; SrcBE = 32'd0;
    #1 check("addStall", 32'(StallDivE), 32'd0);
    nextCycle();
    DivStartE = 1'b0;
    check("addBusy", 32'(DivBusy), 32'd0);
    nextCycle();
    check("addDbz", 32'(DivByZero), 32'd0);
    check("addHoldQ", QuotientOut, 32'd14);

    // Back-to-back: start held through DONE is taken only in the following IDLE cycle.
    startOp(UDIV, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    n = 0;
    while (!DivDone && n < 40) begin
      nextCycle();
      n++;
    end
    check("b2bFirstDoneSeen", 32'(DivDone), 32'd1);
    DivStartE = 1'b1; ALUControlE = UDIV; SrcAE = 32'd77; SrcBE = 32'd8;
    begin
      exp_t e;
      e.q = 32'd9; e.r = 32'd5; e.dbz = 1'b0; e.doneCyc = cyc + 1 + WIDTH + 2;
      sb.push_back(e);
    end
    #1 check("b2bStallInDone", 32'(StallDivE), 32'd0);
    nextCycle();
    check("b2bStallInIdle", 32'(StallDivE), 32'd1);
    nextCycle();
    DivStartE = 1'b0;
    check("b2bBusy", 32'(DivBusy), 32'd1);
    waitDrain(60);

    // Asynchronous reset in the middle of RUN.
    startOp(SDIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (5) nextCycle();
    reset = 1'b0;
    #1;
    check("midRstQuotient", QuotientOut, 32'd0);
    check("midRstRemainder", RemainderOut, 32'd0);
    check("midRstBusy", 32'(DivBusy), 32'd0);
    check("midRstStall", 32'(StallDivE), 32'd0);
    check("midRstDone", 32'(DivDone), 32'd0);
    check("midRstDbz", 32'(DivByZero), 32'd0);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    startOp(UDIV, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 1'b1);
    waitDrain(60);
    repeat (3) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
